// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register master.
// Frame layout, mode bit indices and FSM state encoding.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_LSB   = 8;
  localparam int CPOL_IDX   = 1;
  localparam int CPHA_IDX   = 0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_reg_master_clk_gen.sv
// SPI clock generator: CLK_DIV divider plus 5-bit half-period counter.
// Ports: i_clr clears divider, i_run enables SHIFT toggling, i_cpol idle
// level; o_div divider value, o_lead/o_trail/o_last edge strobes, o_sclk.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       ena,
  input  logic       i_clr,
  input  logic       i_run,
  input  logic       i_cpol,
  output logic [7:0] o_div,
  output logic       o_lead,
  output logic       o_trail,
  output logic       o_last,
  output logic       o_sclk
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] r_div;
  logic [4:0] r_half;
  logic       r_sclk;
  logic       w_tick;

  assign w_tick  = ena && i_run && (r_div == DIV_M1);
  // Even half-periods end on a leading edge, odd ones on a trailing edge.
  assign o_lead  = w_tick && !r_half[0];
  assign o_trail = w_tick && r_half[0];
  assign o_last  = w_tick && (r_half == 5'd31);
  assign o_div   = r_div;
  assign o_sclk  = r_sclk;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_div  <= 8'd0;
      r_half <= 5'd0;
      r_sclk <= 1'b0;
    end else if (ena) begin
      if (i_clr || w_tick) r_div <= 8'd0;
      else                 r_div <= r_div + 8'd1;

      if (!i_run)      r_half <= 5'd0;
      else if (w_tick) r_half <= r_half + 5'd1;

      if (!i_run)      r_sclk <= i_cpol;
      else if (w_tick) r_sclk <= ~r_sclk;
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// SPI initiator turning one register request into a 16-bit frame.
// Ports: host side clk/rstb/ena/mode/start/rw/addr/wdata -> busy/done/
// rdata; pin side spi_cs_n/spi_clk/spi_mosi out, spi_miso in.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int REG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0]  wdata,
  output logic                  busy,
  output logic                  done,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] DIV_N  = 8'(CLK_DIV);

  state_t r_state;
  state_t w_next;

  logic [1:0]            r_mode;
  logic                  r_rw;
  logic [FRAME_BITS-1:0] r_tx;
  logic [REG_WIDTH-1:0]  r_rx;
  logic [REG_WIDTH-1:0]  r_rdata;
  logic                  r_cs_n;
  logic                  r_mosi;
  logic                  r_busy;
  logic                  r_done;

  logic [FRAME_BITS-1:0] w_frame;
  logic [7:0]            w_div;
  logic                  w_lead;
  logic                  w_trail;
  logic                  w_last;
  logic                  w_sclk;
  logic                  w_clr;
  logic                  w_run;
  logic                  w_cpol;
  logic                  w_cpha;
  logic                  w_accept;
  logic                  w_hold_end;
  logic                  w_gap_end;

  always_comb begin
    w_frame = '0;
    w_frame[RW_BIT] = rw;
    w_frame[ADDR_LSB +: ADDR_WIDTH] = addr;
    if (rw) w_frame[REG_WIDTH-1:0] = wdata;
  end

  assign w_run  = (r_state == SHIFT);
  assign w_cpha = r_mode[CPHA_IDX];
  // Idle level follows the live mode input; the frame uses the latched one.
  assign w_cpol = (r_state == IDLE) ? mode[CPOL_IDX]
                                    : r_mode[CPOL_IDX];
  assign w_clr  = (r_state == IDLE) || (w_next != r_state);

  assign w_accept   = ena && (r_state == IDLE) && start;
  assign w_hold_end = ena && (r_state == HOLD) && (w_div == DIV_M1);
  // GAP runs one cycle past CLK_DIV, so done lands 1+35*CLK_DIV after accept.
  assign w_gap_end  = ena && (r_state == GAP) && (w_div == DIV_N);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .i_clr   (w_clr),
    .i_run   (w_run),
    .i_cpol  (w_cpol),
    .o_div   (w_div),
    .o_lead  (w_lead),
    .o_trail (w_trail),
    .o_last  (w_last),
    .o_sclk  (w_sclk)
  );

  always_ff @(posedge clk) begin
    if (!rstb) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (ena) begin
      unique case (r_state)
        IDLE:  if (start) w_next = SETUP;
        SETUP: if (w_div == DIV_M1) w_next = SHIFT;
        SHIFT: if (w_last) w_next = HOLD;
        HOLD:  if (w_div == DIV_M1) w_next = GAP;
        GAP:   if (w_div == DIV_N) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_mode  <= 2'b00;
      r_rw    <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_cs_n  <= 1'b1;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mode <= mode;
        r_rw   <= rw;
        r_cs_n <= 1'b0;
        r_busy <= 1'b1;
        r_rx   <= '0;
        if (mode[CPHA_IDX]) begin
          r_mosi <= 1'b0;
          r_tx   <= w_frame;
        end else begin
          r_mosi <= w_frame[FRAME_BITS-1];
          r_tx   <= {w_frame[FRAME_BITS-2:0], 1'b0};
        end
      end
      if (w_lead) begin
        if (w_cpha) begin
          r_mosi <= r_tx[FRAME_BITS-1];
          r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
        end else begin
          r_rx <= {r_rx[REG_WIDTH-2:0], spi_miso};
        end
      end
      if (w_trail) begin
        if (w_cpha) begin
          r_rx <= {r_rx[REG_WIDTH-2:0], spi_miso};
        end else if (!w_last) begin
          r_mosi <= r_tx[FRAME_BITS-1];
          r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
        end
      end
      if (w_hold_end) r_cs_n <= 1'b1;
      if (w_gap_end) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_mosi <= 1'b0;
        if (!r_rw) r_rdata <= r_rx;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign spi_cs_n = r_cs_n;
  assign spi_clk  = w_sclk;
  assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master with a mode-matched SPI slave model.
// Checks framing, latency, read data, abort, start drop and ena freeze.
module tb_spi_reg_master;

  logic       clk = 1'b0;
  logic       rstb;
  logic       ena;
  logic [1:0] mode;
  logic       start;
  logic       rw;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0]  s_mode = 2'b00;
  logic [7:0]  s_resp = 8'h00;
  logic [15:0] s_tx   = 16'h0;
  logic [15:0] s_rx   = 16'h0;
  int          s_edges = 0;
  int          s_ptr   = 0;
  logic        s_cs_prev  = 1'b1;
  logic        s_clk_prev = 1'b0;

  always #5 clk = ~clk;

  spi_reg_master #(
    .CLK_DIV    (4),
    .ADDR_WIDTH (3),
    .REG_WIDTH  (8)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .mode     (mode),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  // Slave: reacts on the falling clk edge to pin changes made at posedge.
  always @(negedge clk) begin
    if (s_cs_prev && !spi_cs_n) begin
      s_tx    = {8'h00, s_resp};
      s_rx    = 16'h0;
      s_edges = 0;
      if (!s_mode[0]) begin
        spi_miso = s_tx[15];
        s_ptr    = 14;
      end else begin
        s_ptr = 15;
      end
    end else if (!spi_cs_n && spi_clk != s_clk_prev) begin
      s_edges++;
      // leading edge leaves the idle (cpol) level
      if ((spi_clk != s_mode[1]) == !s_mode[0]) begin
        s_rx = {s_rx[14:0], spi_mosi};
      end else if (s_ptr >= 0) begin
        spi_miso = s_tx[s_ptr];
        s_ptr--;
      end
    end
    s_cs_prev  = spi_cs_n;
    s_clk_prev = spi_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  bit frz_ok;

  task automatic xfer(input logic [1:0] m, input logic w,
                      input logic [2:0] a, input logic [7:0] wd,
                      input logic [7:0] resp, input int ena_at,
                      input bit dbl, input int rst_at,
                      output int lat, output int lo);
    logic f_clk, f_mosi, f_cs;
    int nd;
    f_clk = 0; f_mosi = 0; f_cs = 0;
    @(negedge clk);
    mode = m; s_mode = m; s_resp = resp;
    rw = w; addr = a; wdata = wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    lo = spi_cs_n ? 0 : 1;
    frz_ok = 1'b1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      if (!spi_cs_n) lo++;
      if (done) begin
        lat = n;
        break;
      end
      if (rst_at == n) begin
        rstb = 1'b0;
        @(posedge clk); #1;
        chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
        chk("abort_sclk", 32'(spi_clk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rstb = 1'b1;
        nd = 0;
        for (int k = 0; k < 200; k++) begin
          @(posedge clk); #1;
          if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        lat = -1;
        return;
      end
      start = (dbl && (n == 10 || n == 50));
      if (ena_at > 0 && n == ena_at) begin
        f_clk = spi_clk; f_mosi = spi_mosi; f_cs = spi_cs_n;
        ena = 1'b0;
      end else if (ena_at > 0 && n > ena_at && n <= ena_at + 20) begin
        if (spi_clk !== f_clk || spi_mosi !== f_mosi || spi_cs_n !== f_cs)
          frz_ok = 1'b0;
        if (n == ena_at + 20) ena = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, lo, nd, nf;
    logic pcs;
    rstb = 1'b0; ena = 1'b1; start = 1'b0; mode = 2'b00;
    rw = 1'b0; addr = 3'd0; wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sclk", 32'(spi_clk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    rstb = 1'b1;
    repeat (3) @(posedge clk);

    xfer(2'b00, 1'b1, 3'd2, 8'h35, 8'hEE, 0, 1'b0, 0, lat, lo);
    chk("w0_latency", 32'(lat), 32'd141);
    chk("w0_cs_low", 32'(lo), 32'd136);
    chk("w0_frame", 32'(s_rx), 32'h8235);
    chk("w0_edges", 32'(s_edges), 32'd32);
    chk("w0_rdata", 32'(rdata), 32'h00);

    @(negedge clk); mode = 2'b11;
    @(posedge clk); #1;
    chk("r3_idle_pre", 32'(spi_clk), 32'd1);
    xfer(2'b11, 1'b0, 3'd4, 8'h99, 8'hC4, 0, 1'b0, 0, lat, lo);
    chk("r3_latency", 32'(lat), 32'd141);
    chk("r3_rdata", 32'(rdata), 32'hC4);
    chk("r3_frame", 32'(s_rx), 32'h0400);
    @(posedge clk); #1;
    chk("r3_idle_post", 32'(spi_clk), 32'd1);

    for (int m = 0; m < 4; m++) begin
      @(negedge clk); mode = 2'(m);
      repeat (2) @(posedge clk);
      xfer(2'(m), 1'b0, 3'd5, 8'h00, 8'h10, 0, 1'b0, 0, lat, lo);
      chk($sformatf("m%0d_rd_rdata", m), 32'(rdata), 32'h10);
      chk($sformatf("m%0d_rd_frame", m), 32'(s_rx), 32'h0500);
      chk($sformatf("m%0d_rd_edges", m), 32'(s_edges), 32'd32);
      xfer(2'(m), 1'b1, 3'd0, 8'hA5, 8'h66, 0, 1'b0, 0, lat, lo);
      chk($sformatf("m%0d_wr_frame", m), 32'(s_rx), 32'h80A5);
      chk($sformatf("m%0d_wr_edges", m), 32'(s_edges), 32'd32);
      chk($sformatf("m%0d_wr_latency", m), 32'(lat), 32'd141);
    end

    @(negedge clk); mode = 2'b00;
    repeat (2) @(posedge clk);
    xfer(2'b00, 1'b1, 3'd3, 8'h11, 8'h00, 0, 1'b1, 0, lat, lo);
    chk("dbl_latency", 32'(lat), 32'd141);
    chk("dbl_frame", 32'(s_rx), 32'h8311);
    nd = 0; nf = 0; pcs = spi_cs_n;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (pcs && !spi_cs_n) nf++;
      pcs = spi_cs_n;
    end
    chk("dbl_extra_done", 32'(nd), 32'd0);
    chk("dbl_extra_frame", 32'(nf), 32'd0);

    xfer(2'b00, 1'b1, 3'd6, 8'h77, 8'h00, 0, 1'b0, 60, lat, lo);
    @(negedge clk); mode = 2'b01;
    repeat (2) @(posedge clk);
    xfer(2'b01, 1'b1, 3'd7, 8'h3C, 8'h00, 0, 1'b0, 0, lat, lo);
    chk("post_rst_latency", 32'(lat), 32'd141);
    chk("post_rst_frame", 32'(s_rx), 32'h873C);

    @(negedge clk); mode = 2'b00;
    repeat (2) @(posedge clk);
    xfer(2'b00, 1'b0, 3'd1, 8'h00, 8'h5A, 50, 1'b0, 0, lat, lo);
    chk("ena_latency", 32'(lat), 32'd161);
    chk("ena_rdata", 32'(rdata), 32'h5A);
    chk("ena_frozen", 32'(frz_ok), 32'd1);
    chk("ena_frame", 32'(s_rx), 32'h0100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
